// File: rtl/decode_issue.sv
// Single-entry decode/issue stage with register scoreboard and per-channel routing.
// Optional build macro: DECODE_ISSUE_WB_BYPASS_EN (same-cycle writeback bypass into the hazard check).
module decode_issue #(
  parameter logic [2:0] p_tinyrv1    = 3'b111,
  parameter logic [2:0] p_isa_subset = p_tinyrv1,
  parameter int         p_num_pipes  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            F__inst,
  input  logic                   F__val,
  output logic                   F__rdy,
  output logic [3:0]             X__uop,
  output logic [4:0]             X__raddr0,
  output logic [4:0]             X__raddr1,
  output logic [4:0]             X__waddr,
  output logic                   X__wen,
  output logic [31:0]            X__imm,
  output logic                   X__op2_sel,
  output logic [p_num_pipes-1:0] X__val,
  input  logic [p_num_pipes-1:0] X__rdy,
  input  logic                   W__val,
  input  logic [4:0]             W__waddr,
  output logic                   illegal
);

  localparam int ISA_ADD  = 0;
  localparam int ISA_ADDI = 1;
  localparam int ISA_MUL  = 2;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;

  localparam logic OP2_RF  = 1'b0;
  localparam logic OP2_IMM = 1'b1;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  localparam int CH_MUL = p_num_pipes - 1;

  function automatic logic signed [31:0] sext12(input logic signed [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

  logic        valid_q;
  logic [31:0] inst_q;
  logic [31:0] pending_q;
  logic [31:0] pending_n;
  logic [31:0] pending_eff;
  logic        is_add;
  logic        is_addi;
  logic        is_mul;
  logic        legal;
  logic        hazard;
  logic        issue_ok;
  logic        fire;
  logic        drain;
  int          sel_ch;

  // Decode stage: payload is purely combinational from the held instruction
  always_comb begin
    is_add  = p_isa_subset[ISA_ADD] && (inst_q[6:0] == OPC_OP) &&
              (inst_q[14:12] == 3'b000) && (inst_q[31:25] == 7'b0000000);
    is_mul  = p_isa_subset[ISA_MUL] && (inst_q[6:0] == OPC_OP) &&
              (inst_q[14:12] == 3'b000) && (inst_q[31:25] == 7'b0000001);
    is_addi = p_isa_subset[ISA_ADDI] && (inst_q[6:0] == OPC_OPIMM) &&
              (inst_q[14:12] == 3'b000);
    legal   = is_add || is_addi || is_mul;

    X__uop     = is_mul ? OP_MUL : ((is_add || is_addi) ? OP_ADD : OP_NOP);
    X__raddr0  = inst_q[19:15];
    X__raddr1  = inst_q[24:20];
    X__waddr   = inst_q[11:7];
    X__wen     = legal;
    X__imm     = sext12(inst_q[31:20]);
    X__op2_sel = is_addi ? OP2_IMM : OP2_RF;
  end

  always_comb begin
`ifdef DECODE_ISSUE_WB_BYPASS_EN
    pending_eff = pending_q & ~(W__val ? (32'd1 << W__waddr) : 32'd0);
`else
    pending_eff = pending_q;
`endif
    hazard = pending_eff[X__raddr0] ||
             ((X__op2_sel == OP2_RF) && pending_eff[X__raddr1]) ||
             (X__wen && pending_eff[X__waddr]);
  end

  // Issue stage: route to one channel, drain on fire or illegal discard
  always_comb begin
    issue_ok = !rst && valid_q && legal && !hazard;
    sel_ch   = is_mul ? CH_MUL : 0;
    X__val   = '0;
    for (int i = 0; i < p_num_pipes; i++) begin
      X__val[i] = issue_ok && (i == sel_ch);
    end
    fire    = |(X__val & X__rdy);
    illegal = !rst && valid_q && !legal;
    drain   = fire || illegal;
    F__rdy  = !rst && (!valid_q || drain);
  end

  always_comb begin
    pending_n = pending_q;
    if (W__val) begin
      pending_n[W__waddr] = 1'b0;
    end
    if (fire && X__wen && (X__waddr != 5'd0)) begin
      pending_n[X__waddr] = 1'b1;
    end
    pending_n[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      pending_q <= '0;
    end else begin
      pending_q <= pending_n;
      if (F__val && F__rdy) begin
        valid_q <= 1'b1;
      end else if (drain) begin
        valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (F__val && F__rdy) begin
      inst_q <= F__inst;
    end
  end

endmodule

// File: tb/tb_decode_issue.sv
// Randomized self-checking bench for decode_issue against a cycle-level reference model.
module tb_decode_issue;

  localparam int NP = 2;
  localparam logic [3:0] U_NOP = 4'd0;
  localparam logic [3:0] U_ADD = 4'd1;
  localparam logic [3:0] U_MUL = 4'd2;
`ifdef DECODE_ISSUE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   F__inst;
  logic          F__val;
  logic          F__rdy;
  logic [3:0]    X__uop;
  logic [4:0]    X__raddr0;
  logic [4:0]    X__raddr1;
  logic [4:0]    X__waddr;
  logic          X__wen;
  logic [31:0]   X__imm;
  logic          X__op2_sel;
  logic [NP-1:0] X__val;
  logic [NP-1:0] X__rdy;
  logic          W__val;
  logic [4:0]    W__waddr;
  logic          illegal;

  always #5 clk = ~clk;

  decode_issue #(.p_num_pipes(NP)) dut (
    .clk(clk), .rst(rst), .F__inst(F__inst), .F__val(F__val), .F__rdy(F__rdy),
    .X__uop(X__uop), .X__raddr0(X__raddr0), .X__raddr1(X__raddr1),
    .X__waddr(X__waddr), .X__wen(X__wen), .X__imm(X__imm), .X__op2_sel(X__op2_sel),
    .X__val(X__val), .X__rdy(X__rdy), .W__val(W__val), .W__waddr(W__waddr),
    .illegal(illegal)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference state: what the decode slot holds and which registers await writeback
  bit        m_valid = 1'b0;
  bit [31:0] m_inst  = '0;
  bit        m_pend[32];

  function automatic bit [31:0] mk_r(input bit [6:0] f7, input bit [4:0] rs2,
                                     input bit [4:0] rs1, input bit [4:0] rd);
    return {f7, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction

  function automatic bit [31:0] mk_i(input bit [11:0] imm, input bit [4:0] rs1,
                                     input bit [4:0] rd);
    return {imm, rs1, 3'b000, rd, 7'h13};
  endfunction

  function automatic void ref_decode(input bit [31:0] ins, output bit ok,
                                     output bit [3:0] uop, output bit imm_form,
                                     output bit [31:0] imm);
    int v;
    ok = 1'b0; uop = U_NOP; imm_form = 1'b0;
    v = int'(ins[31:20]);
    if (v >= 2048) v = v - 4096;
    imm = 32'(v);
    if (ins[6:0] == 7'h33 && ins[14:12] == 3'd0 && ins[31:25] == 7'd0) begin
      ok = 1'b1; uop = U_ADD;
    end else if (ins[6:0] == 7'h33 && ins[14:12] == 3'd0 && ins[31:25] == 7'd1) begin
      ok = 1'b1; uop = U_MUL;
    end else if (ins[6:0] == 7'h13 && ins[14:12] == 3'd0) begin
      ok = 1'b1; uop = U_ADD; imm_form = 1'b1;
    end
  endfunction

  function automatic bit busy(input bit [4:0] r, input bit wv, input bit [4:0] wa);
    return m_pend[r] && !(BYP && wv && (wa == r));
  endfunction

  task automatic step(input bit r, input bit fv, input bit [31:0] fi,
                      input bit [NP-1:0] xr, input bit wv, input bit [4:0] wa);
    bit ok, immf, hz, fire, exp_ill, exp_rdy;
    bit [3:0] uop;
    bit [31:0] imm;
    bit [4:0] rs1, rs2, rd;
    bit [NP-1:0] exp_val;
    @(negedge clk);
    rst = r; F__val = fv; F__inst = fi; X__rdy = xr; W__val = wv; W__waddr = wa;
    #1;
    ref_decode(m_inst, ok, uop, immf, imm);
    rs1 = m_inst[19:15]; rs2 = m_inst[24:20]; rd = m_inst[11:7];
    hz = busy(rs1, wv, wa) || (!immf && busy(rs2, wv, wa)) || busy(rd, wv, wa);
    exp_val = '0;
    if (!r && m_valid && ok && !hz) begin
      if (uop == U_MUL) exp_val[NP-1] = 1'b1;
      else exp_val[0] = 1'b1;
    end
    exp_ill = !r && m_valid && !ok;
    fire    = |(exp_val & xr);
    exp_rdy = !r && (!m_valid || fire || exp_ill);

    check_eq("x_val", 32'(X__val), 32'(exp_val));
    check_eq("illegal", 32'(illegal), 32'(exp_ill));
    check_eq("f_rdy", 32'(F__rdy), 32'(exp_rdy));
    if (|exp_val) begin
      check_eq("uop", 32'(X__uop), 32'(uop));
      check_eq("raddr0", 32'(X__raddr0), 32'(rs1));
      check_eq("waddr", 32'(X__waddr), 32'(rd));
      check_eq("wen", 32'(X__wen), 32'd1);
      check_eq("op2_sel", 32'(X__op2_sel), 32'(immf));
      if (immf) check_eq("imm", X__imm, imm);
      else check_eq("raddr1", 32'(X__raddr1), 32'(rs2));
    end

    if (r) begin
      m_valid = 1'b0;
      foreach (m_pend[k]) m_pend[k] = 1'b0;
    end else begin
      if (wv) m_pend[wa] = 1'b0;
      if (fire && rd != 5'd0) m_pend[rd] = 1'b1;
      if (fv && exp_rdy) begin
        m_valid = 1'b1;
        m_inst  = fi;
      end else if (fire || exp_ill) begin
        m_valid = 1'b0;
      end
    end
  endtask

  function automatic bit [31:0] rand_inst();
    bit [4:0] a, b, d;
    a = 5'($urandom_range(0, 7));
    b = 5'($urandom_range(0, 7));
    d = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 9))
      0, 1, 2: return mk_r(7'd0, b, a, d);
      3, 4:    return mk_i(12'($urandom), a, d);
      5, 6:    return mk_r(7'd1, b, a, d);
      7:       return mk_r(7'h20, b, a, d);
      8:       return {12'($urandom), a, 3'b001, d, 7'h13};
      default: return {25'($urandom), 7'h03};
    endcase
  endfunction

  initial begin
    foreach (m_pend[k]) m_pend[k] = 1'b0;
    rst = 1'b1; F__val = 1'b0; F__inst = '0; X__rdy = '0; W__val = 1'b0; W__waddr = '0;

    step(1, 0, 0, 2'b00, 0, 0);
    step(1, 0, 0, 2'b00, 0, 0);
    step(0, 0, 0, 2'b00, 0, 0);

    // ADDI x1,x0,5 then dependent ADD x2,x1,x1 released by writeback of x1
    step(0, 1, 32'h00500093, 2'b01, 0, 0);
    step(0, 1, mk_r(7'd0, 5'd1, 5'd1, 5'd2), 2'b01, 0, 0);
    step(0, 0, 0, 2'b01, 0, 0);
    step(0, 0, 0, 2'b01, 0, 0);
    step(0, 0, 0, 2'b01, 1, 5'd1);
    step(0, 0, 0, 2'b01, 0, 0);
    step(0, 0, 0, 2'b01, 1, 5'd2);

    // MUL on channel 1 blocks the following ADD until channel 1 is ready
    step(0, 1, mk_r(7'd1, 5'd5, 5'd4, 5'd3), 2'b01, 0, 0);
    step(0, 1, mk_r(7'd0, 5'd8, 5'd7, 5'd6), 2'b01, 0, 0);
    step(0, 1, mk_r(7'd0, 5'd8, 5'd7, 5'd6), 2'b01, 0, 0);
    step(0, 1, mk_r(7'd0, 5'd8, 5'd7, 5'd6), 2'b11, 0, 0);
    step(0, 0, 0, 2'b11, 0, 0);
    step(0, 0, 0, 2'b11, 0, 0);

    // Illegal encodings are discarded with a single pulse
    step(0, 1, mk_r(7'h20, 5'd2, 5'd1, 5'd3), 2'b11, 0, 0);
    step(0, 1, 32'h00000003, 2'b11, 0, 0);
    step(0, 0, 0, 2'b11, 0, 0);
    step(0, 0, 0, 2'b11, 0, 0);

    // Writes to x0 never mark it pending
    step(1, 0, 0, 2'b00, 0, 0);
    step(0, 1, mk_r(7'd0, 5'd2, 5'd1, 5'd0), 2'b01, 0, 0);
    step(0, 1, mk_i(12'hfff, 5'd0, 5'd0), 2'b01, 0, 0);
    step(0, 1, mk_r(7'd0, 5'd0, 5'd0, 5'd9), 2'b01, 0, 0);
    step(0, 0, 0, 2'b01, 0, 0);

    // Set of x4 on fire wins over simultaneous clear; then reset while holding
    step(0, 1, mk_i(12'd1, 5'd0, 5'd4), 2'b01, 0, 0);
    step(0, 1, mk_r(7'd0, 5'd4, 5'd4, 5'd10), 2'b01, 1, 5'd4);
    step(0, 0, 0, 2'b01, 0, 0);
    step(0, 0, 0, 2'b01, 0, 0);
    step(1, 0, 0, 2'b01, 1, 5'd4);
    step(0, 0, 0, 2'b01, 0, 0);
    step(0, 1, mk_r(7'd0, 5'd4, 5'd4, 5'd11), 2'b00, 0, 0);
    step(0, 0, 0, 2'b00, 0, 0);
    step(1, 0, 0, 2'b00, 0, 0);
    step(0, 0, 0, 2'b11, 0, 0);

    for (int c = 0; c < 4000; c++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), rand_inst(),
           NP'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0),
           5'($urandom_range(0, 7)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
